// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings, response constants and SRAM slave FSM state type
package ahb_pkg;
  typedef enum logic [1:0] {HTRANS_IDLE = 2'd0, HTRANS_BUSY = 2'd1, HTRANS_NONSEQ = 2'd2, HTRANS_SEQ = 2'd3} htrans_e;
  typedef enum logic [2:0] {HSIZE_BYTE = 3'd0, HSIZE_HALF = 3'd1, HSIZE_WORD = 3'd2} hsize_e;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_HAZ, S_ERR1, S_ERR2} state_e;
  function automatic logic [3:0] lane_en(logic [2:0] size, logic [1:0] a);
    return size == HSIZE_BYTE ? 4'b0001 << a : size == HSIZE_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/ahb_sram_slave_bank.sv
// sram_bank: 32-bit simple dual-port RAM, registered read, per-byte write enables.
// Ports: clk; re_i/raddr_i read request; we_i/waddr_i/be_i/wdata_i byte-masked write; rdata_o read word.
module sram_bank #(
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [3:0]    be_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem_q[raddr_i];
    for (int b = 0; b < 4; b++)
      if (we_i && be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite subordinate fronting a word-organised SRAM with WAIT_STATES wait cycles.
// Ports: clk, rst (async, active high); ahb_s0_h*_i address/control/write data; ahb_s0_hready_o,
// ahb_s0_hresp_o, ahb_s0_hrdata_o response. Define AHB_SRAM_ERR_EN to answer illegal sizes and
// misaligned transfers with a two-cycle ERROR; otherwise they are aligned down and hresp is OKAY.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int AWID        = 12,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ahb_s0_haddr_i,
  input  logic        ahb_s0_hwrite_i,
  input  logic [2:0]  ahb_s0_hsize_i,
  input  logic [2:0]  ahb_s0_hburst_i,
  input  logic [3:0]  ahb_s0_hprot_i,
  input  logic [1:0]  ahb_s0_htrans_i,
  input  logic        ahb_s0_hmastlock_i,
  input  logic [31:0] ahb_s0_hwdata_i,
  output logic        ahb_s0_hready_o,
  output logic        ahb_s0_hresp_o,
  output logic [31:0] ahb_s0_hrdata_o
);
  localparam int WW = AWID - 2;
  localparam logic [2:0] WS_M1 = WAIT_STATES > 0 ? 3'(WAIT_STATES - 1) : 3'd0;
  state_e state_q, state_d, start_s;
  logic [2:0] cnt_q, cnt_d;
  logic [AWID-1:0] addr_q;
  logic write_q;
  logic [2:0] size_q;
  logic hready_q, hready_d;
  logic accept, haz, err;
  logic [31:0] ram_rdata;
  logic unused_ok;
  assign unused_ok = ^{ahb_s0_hburst_i, ahb_s0_hprot_i, ahb_s0_hmastlock_i, ahb_s0_htrans_i[0], ahb_s0_haddr_i[31:AWID]};
  assign accept = hready_q & ahb_s0_htrans_i[1];
`ifdef AHB_SRAM_ERR_EN
  logic hresp_q, hresp_d;
  assign err = ahb_s0_hsize_i > HSIZE_WORD || (ahb_s0_hsize_i == HSIZE_HALF && ahb_s0_haddr_i[0]) ||
               (ahb_s0_hsize_i == HSIZE_WORD && ahb_s0_haddr_i[1:0] != 2'd0);
  assign hresp_d = state_d == S_ERR1 || state_d == S_ERR2;
  assign ahb_s0_hresp_o = hresp_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) hresp_q <= HRESP_OKAY;
    else hresp_q <= hresp_d;
`else
  assign err = 1'b0;
  assign ahb_s0_hresp_o = HRESP_OKAY;
`endif
  // A read accepted as a write commits to the same word sees stale RAM output; stall and re-read.
  assign haz = state_q == S_DATA && write_q && !ahb_s0_hwrite_i && ahb_s0_haddr_i[AWID-1:2] == addr_q[AWID-1:2];
  always_comb begin
    start_s = err ? S_ERR1 : haz ? S_HAZ : WAIT_STATES > 0 ? S_WAIT : S_DATA;
    state_d = S_IDLE;
    case (state_q)
      S_IDLE, S_DATA: state_d = accept ? start_s : S_IDLE;
      S_WAIT: state_d = cnt_q == 3'd0 ? S_DATA : S_WAIT;
      S_HAZ: state_d = WAIT_STATES > 0 ? S_WAIT : S_DATA;
`ifdef AHB_SRAM_ERR_EN
      S_ERR1: state_d = S_ERR2;
      S_ERR2: state_d = accept ? start_s : S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
    cnt_d = (state_d == S_WAIT && state_q != S_WAIT) ? WS_M1 : state_q == S_WAIT ? cnt_q - 3'd1 : cnt_q;
    hready_d = state_d == S_IDLE || state_d == S_DATA || state_d == S_ERR2;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 3'd0;
      hready_q <= 1'b1;
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hready_q <= hready_d;
      if (accept) begin
        addr_q  <= ahb_s0_haddr_i[AWID-1:0];
        write_q <= ahb_s0_hwrite_i;
        size_q  <= ahb_s0_hsize_i;
      end
    end
  sram_bank #(.DEPTH(1 << WW)) u_bank (
    .clk     (clk),
    .re_i    (accept || state_q == S_HAZ),
    .raddr_i (state_q == S_HAZ ? addr_q[AWID-1:2] : ahb_s0_haddr_i[AWID-1:2]),
    .we_i    (state_q == S_DATA && write_q),
    .waddr_i (addr_q[AWID-1:2]),
    .be_i    (lane_en(size_q, addr_q[1:0])),
    .wdata_i (ahb_s0_hwdata_i),
    .rdata_o (ram_rdata)
  );
  assign ahb_s0_hready_o = hready_q;
  assign ahb_s0_hrdata_o = (state_q == S_DATA && !write_q) ? ram_rdata : 32'd0;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: table-driven scoreboard bench for two slaves (WAIT_STATES=2 and 0)
module tb_ahb_sram_slave;
`ifdef AHB_SRAM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  typedef struct {
    int d;
    logic [31:0] a;
    logic w;
    logic [2:0] sz;
    logic [31:0] wd;
    int ew;
    logic [31:0] er;
    logic eresp;
  } vec_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] haddr [2], hwdata [2], hrdata [2];
  logic hwrite [2], hready [2], hresp [2];
  logic [2:0] hsize [2];
  logic [1:0] htrans [2];
  int n_cmp = 0, n_bad = 0;
  vec_t tbl [$], sb [$];
  always #5 clk = ~clk;
  ahb_sram_slave #(.AWID(12), .WAIT_STATES(2)) u0 (
    .clk(clk), .rst(rst), .ahb_s0_haddr_i(haddr[0]), .ahb_s0_hwrite_i(hwrite[0]), .ahb_s0_hsize_i(hsize[0]),
    .ahb_s0_hburst_i(3'd0), .ahb_s0_hprot_i(4'd3), .ahb_s0_htrans_i(htrans[0]), .ahb_s0_hmastlock_i(1'b0),
    .ahb_s0_hwdata_i(hwdata[0]), .ahb_s0_hready_o(hready[0]), .ahb_s0_hresp_o(hresp[0]), .ahb_s0_hrdata_o(hrdata[0]));
  ahb_sram_slave #(.AWID(12), .WAIT_STATES(0)) u1 (
    .clk(clk), .rst(rst), .ahb_s0_haddr_i(haddr[1]), .ahb_s0_hwrite_i(hwrite[1]), .ahb_s0_hsize_i(hsize[1]),
    .ahb_s0_hburst_i(3'd0), .ahb_s0_hprot_i(4'd3), .ahb_s0_htrans_i(htrans[1]), .ahb_s0_hmastlock_i(1'b0),
    .ahb_s0_hwdata_i(hwdata[1]), .ahb_s0_hready_o(hready[1]), .ahb_s0_hresp_o(hresp[1]), .ahb_s0_hrdata_o(hrdata[1]));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(int d, logic [31:0] a, logic w, logic [2:0] sz, logic [31:0] wd, int ew, logic [31:0] er, logic eresp);
    vec_t v;
    v.d = d; v.a = a; v.w = w; v.sz = sz; v.wd = wd; v.ew = ew; v.er = er; v.eresp = eresp;
    return v;
  endfunction
  // One isolated transfer: an idle cycle, the address phase, then the data phase until hready.
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd,
                      output int waits, output logic [31:0] rd, output logic r_or, output logic r_and);
    @(negedge clk);
    haddr[d] = a; hwrite[d] = w; hsize[d] = sz; htrans[d] = 2'b10;
    @(negedge clk);
    htrans[d] = 2'b00; hwdata[d] = wd;
    waits = 0; r_or = hresp[d]; r_and = hresp[d];
    while (!hready[d] && waits < 20) begin
      @(negedge clk);
      waits++;
      r_or |= hresp[d];
      r_and &= hresp[d];
    end
    rd = hrdata[d];
  endtask
  initial begin
    int waits;
    logic [31:0] rd;
    logic r_or, r_and;
    vec_t e;
    for (int d = 0; d < 2; d++) begin
      haddr[d] = 0; hwdata[d] = 0; hwrite[d] = 0; hsize[d] = 3'd2; htrans[d] = 2'b00;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready%0d", d), 32'(hready[d]), 32'd1);
      chk($sformatf("rst_resp%0d", d), 32'(hresp[d]), 32'd0);
      chk($sformatf("rst_rdata%0d", d), hrdata[d], 32'd0);
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int d = 0; d < 2; d++) begin
        htrans[d] = c[0] ? 2'b01 : 2'b00; haddr[d] = 32'h10; hwrite[d] = c[1];
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("idle%0d_ready%0d", c, d), 32'(hready[d]), 32'd1);
        chk($sformatf("idle%0d_resp%0d", c, d), 32'(hresp[d]), 32'd0);
        chk($sformatf("idle%0d_rdata%0d", c, d), hrdata[d], 32'd0);
      end
    end
    for (int d = 0; d < 2; d++) htrans[d] = 2'b00;
    tbl.push_back(mk(0, 32'h010, 1, 3'd2, 32'hDEADBEEF, 2, 32'h0, 0));
    tbl.push_back(mk(0, 32'h010, 0, 3'd2, 32'h0, 2, 32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 32'h010, 1, 3'd2, 32'h11223344, 2, 32'h0, 0));
    tbl.push_back(mk(0, 32'h013, 1, 3'd0, 32'hAA000000, 2, 32'h0, 0));
    tbl.push_back(mk(0, 32'h010, 0, 3'd2, 32'h0, 2, 32'hAA223344, 0));
    tbl.push_back(mk(0, 32'h010, 1, 3'd1, 32'h00005566, 2, 32'h0, 0));
    tbl.push_back(mk(0, 32'h010, 0, 3'd2, 32'h0, 2, 32'hAA225566, 0));
    tbl.push_back(mk(0, 32'h1010, 0, 3'd2, 32'h0, 2, 32'hAA225566, 0));
    tbl.push_back(mk(0, 32'h012, 1, 3'd1, 32'h77880000, 2, 32'h0, 0));
    tbl.push_back(mk(0, 32'h010, 0, 3'd2, 32'h0, 2, 32'h77885566, 0));
    tbl.push_back(mk(0, 32'h000, 1, 3'd2, 32'h01010101, 2, 32'h0, 0));
    tbl.push_back(mk(0, 32'h004, 1, 3'd2, 32'h44444444, 2, 32'h0, 0));
    tbl.push_back(mk(0, 32'h002, 1, 3'd2, 32'hCAFEF00D, ERR ? 1 : 2, 32'h0, ERR));
    tbl.push_back(mk(0, 32'h000, 0, 3'd2, 32'h0, 2, ERR ? 32'h01010101 : 32'hCAFEF00D, 0));
    tbl.push_back(mk(0, 32'h004, 1, 3'd3, 32'h0BADBEEF, ERR ? 1 : 2, 32'h0, ERR));
    tbl.push_back(mk(0, 32'h004, 0, 3'd2, 32'h0, 2, ERR ? 32'h44444444 : 32'h0BADBEEF, 0));
    tbl.push_back(mk(0, 32'h001, 0, 3'd1, 32'h0, ERR ? 1 : 2, ERR ? 32'h0 : 32'hCAFEF00D, ERR));
    tbl.push_back(mk(1, 32'h100, 1, 3'd2, 32'h55AA55AA, 0, 32'h0, 0));
    tbl.push_back(mk(1, 32'h100, 0, 3'd2, 32'h0, 0, 32'h55AA55AA, 0));
    tbl.push_back(mk(1, 32'h101, 1, 3'd0, 32'h0000BB00, 0, 32'h0, 0));
    tbl.push_back(mk(1, 32'h100, 0, 3'd2, 32'h0, 0, 32'h55AABBAA, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      sb.push_back(tbl[i]);
      xfer(tbl[i].d, tbl[i].a, tbl[i].w, tbl[i].sz, tbl[i].wd, waits, rd, r_or, r_and);
      e = sb.pop_front();
      chk($sformatf("v%0d_waits", i), 32'(waits), 32'(e.ew));
      chk($sformatf("v%0d_rdata", i), rd, e.er);
      chk($sformatf("v%0d_resp_any", i), 32'(r_or), 32'(e.eresp));
      chk($sformatf("v%0d_resp_all", i), 32'(r_and), 32'(e.eresp));
    end
    @(negedge clk);
    haddr[1] = 32'h020; hwrite[1] = 1; hsize[1] = 3'd2; htrans[1] = 2'b10;
    @(negedge clk);
    chk("haz_wr_ready", 32'(hready[1]), 32'd1);
    hwdata[1] = 32'h12345678; hwrite[1] = 0;
    @(negedge clk);
    htrans[1] = 2'b00;
    chk("haz_stall", 32'(hready[1]), 32'd0);
    chk("haz_stall_rdata", hrdata[1], 32'd0);
    @(negedge clk);
    chk("haz_ready", 32'(hready[1]), 32'd1);
    chk("haz_rdata", hrdata[1], 32'h12345678);
    xfer(1, 32'h024, 1, 3'd2, 32'h0A0B0C0D, waits, rd, r_or, r_and);
    chk("nohaz_init_waits", 32'(waits), 32'd0);
    @(negedge clk);
    haddr[1] = 32'h020; hwrite[1] = 1; hsize[1] = 3'd2; htrans[1] = 2'b10;
    @(negedge clk);
    hwdata[1] = 32'h9999AAAA; haddr[1] = 32'h024; hwrite[1] = 0;
    @(negedge clk);
    htrans[1] = 2'b00;
    chk("nohaz_ready", 32'(hready[1]), 32'd1);
    chk("nohaz_rdata", hrdata[1], 32'h0A0B0C0D);
    xfer(1, 32'h020, 0, 3'd2, 32'h0, waits, rd, r_or, r_and);
    chk("nohaz_wr_landed", rd, 32'h9999AAAA);
    xfer(0, 32'h030, 1, 3'd2, 32'h30303030, waits, rd, r_or, r_and);
    @(negedge clk);
    haddr[0] = 32'h030; hwrite[0] = 1; hsize[0] = 3'd2; htrans[0] = 2'b10;
    @(negedge clk);
    chk("rst_mid_wait", 32'(hready[0]), 32'd0);
    hwdata[0] = 32'hBADBAD00; htrans[0] = 2'b00;
    rst = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(hready[0]), 32'd1);
    chk("rst_mid_resp", 32'(hresp[0]), 32'd0);
    chk("rst_mid_rdata", hrdata[0], 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xfer(0, 32'h030, 0, 3'd2, 32'h0, waits, rd, r_or, r_and);
    chk("rst_keep_waits", 32'(waits), 32'd2);
    chk("rst_keep_rdata", rd, 32'h30303030);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

- AHB-Lite responder (subordinate) exposing a 32-bit word-organised on-chip SRAM with a programmable number of wait states.
- Attaches to any master port of ahb_interconnect, alongside the camera, NPU and output units, as CPU-visible scratch/frame storage.
- Handles single transfers of byte, halfword and word size with lane-accurate writes.
- Optionally returns an AHB ERROR response for illegal transfers.

## Interface

Parameters:
- AWID, 12, byte-address bits decoded; storage is 2^(AWID-2) words.
- WAIT_STATES, 1, wait cycles inserted in every NONSEQ/SEQ data phase; range 0–7.

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ahb_s0_haddr_i  input  32  address; bits [AWID-1:0] used.
- ahb_s0_hwrite_i  input  1  1 = write.
- ahb_s0_hsize_i  input  3  0 = byte, 1 = half, 2 = word.
- ahb_s0_hburst_i  input  3  ignored; every beat is treated as single.
- ahb_s0_hprot_i  input  4  ignored.
- ahb_s0_htrans_i  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- ahb_s0_hmastlock_i  input  1  ignored.
- ahb_s0_hwdata_i  input  32  write data, valid in the data phase.
- ahb_s0_hready_o  output  1  transfer-done / ready; reset value 1.
- ahb_s0_hresp_o  output  1  0 = OKAY, 1 = ERROR; reset value 0.
- ahb_s0_hrdata_o  output  32  read data; reset value 0.

## Operation

Address phase:
- An address phase is accepted on a rising edge when hready_o=1 and htrans_i[1]=1.
- On acceptance, register haddr, hwrite and hsize, and issue the synchronous RAM read for word haddr[AWID-1:2].
- IDLE and BUSY are not accepted; they get zero-wait OKAY (hready_o stays 1).

State machine:
- IDLE → WAIT when a transfer is accepted and WAIT_STATES>0.
- IDLE → DATA when a transfer is accepted and WAIT_STATES=0.
- WAIT counts down the WAIT_STATES cycles with hready_o=0, then goes to DATA.
- DATA is the single final cycle with hready_o=1.
- From DATA: go to IDLE, or, if a new transfer is accepted in that same cycle, restart at WAIT/DATA (back-to-back transfers are pipelined).
- ERR1 and ERR2 are the two ERROR cycles (see Configuration).
- HAZ is a one-cycle read-after-write stall (see Read-after-write).

Reads:
- hrdata_o carries the full addressed word in the DATA cycle; the master selects lanes.
- hrdata_o = 0 in every other cycle.

Writes:
- Byte enables are decoded from the registered hsize and haddr[1:0]:
  - byte: lane haddr[1:0];
  - half: lanes {haddr[1],0} and {haddr[1],1};
  - word: all four lanes.
- hwdata_i is committed to RAM on the rising edge that ends the DATA cycle; only enabled lanes change.

Read-after-write:
- Applies when a read is accepted on the same edge a write commits, to the same word.
- The slave enters HAZ: hready_o=0 for one extra cycle while it re-reads, then DATA.
- The returned word reflects the committed write.
- A read to a different word adds no stall.

Address wrap: bits above AWID-1 are ignored, so addresses alias modulo 2^AWID.

Reset mid-transfer: FSM → IDLE immediately, outputs go to reset values, the pending write is discarded, and RAM contents are not cleared.

## Timing

- Zero-wait read/write: address edge N; DATA in cycle N+1.
- Read latency from address acceptance to valid hrdata_o is WAIT_STATES+1 cycles.
- hready_o is registered; no combinational path from any input to hready_o.
- ERROR response is exactly two cycles: {hready_o=0, hresp_o=1} then {hready_o=1, hresp_o=1}.

## Configuration

Macro: AHB_SRAM_ERR_EN.

Defined:
- hsize_i > 2, a misaligned half (haddr[0]=1), or a misaligned word (haddr[1:0]≠0) gets the two-cycle ERROR.
- No RAM write occurs and hrdata_o = 0.
- An ERROR transfer skips wait states.

Undefined:
- ERR1 and ERR2 are not built; hresp_o is tied to 0.
- The address is aligned down to its natural size.
- hsize > 2 is treated as a word.

## Structure

Package ahb_pkg holds:
- htrans and hsize enums;
- the HRESP_OKAY/HRESP_ERROR constants;
- the FSM state typedef.

Sub-module sram_bank:
- Parameter DEPTH;
- synchronous read and write, with 4 byte-write enables;
- inferable as block RAM.

## Test plan

- Reset, then idle: hready_o=1, hresp_o=0, hrdata_o=0; IDLE/BUSY traffic gets zero-wait OKAY.
- WAIT_STATES=2: word write 0xDEADBEEF to 0x010, then read 0x010 → hready_o low for 2 cycles, then hrdata_o=0xDEADBEEF.
- Byte write 0xAA to 0x013 over word 0x11223344 → read of 0x010 returns 0xAA223344; half write 0x5566 to 0x010 → read returns 0xAA225566.
- Back-to-back pipelined write 0x12345678 to 0x020 with a read of 0x020 in the following address phase, WAIT_STATES=0 → one HAZ stall, then read data 0x12345678. A read of 0x024 in the same position shows no stall.
- AHB_SRAM_ERR_EN defined: word write to 0x002 → two-cycle ERROR, and the RAM word is unchanged. Undefined: the same write lands at 0x000 with OKAY.
- Assert rst during the WAIT cycle of a write to 0x030 → outputs return to reset values; a later read of 0x030 returns its old contents.
